ahb_dma_chan_seq: RTL and testbench

Single-channel DMA transfer sequencer. Runs a read-then-write loop of unit transfers. One shared address incrementer is time-multiplexed between the source and destination pointers. Sits between the DMA register file (configuration, start, abort) and the AHB master interface (req/ack handshake). Exposes progress and completion status back to the register file.

---
 rtl/ahb_dma_chan_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_ahb_dma_chan_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_dma_chan_seq.sv
// ----------------------------------------------------------------------------
// ahb_dma_chan_seq
// Single-channel DMA transfer sequencer. Each unit transfer is one bus read
// followed by one bus write of the captured data. One shared incrementer
// advances the source pointer after the read and the destination pointer
// after the write. The two uses happen in different cycles.
//
// Ports
//   clk, rst_n        : system clock, asynchronous active-low reset
//   start, abort      : one-cycle start pulse; level abort
//   src_addr_i        : initial source address
//   dst_addr_i        : initial destination address
//   tot_sz_i          : number of unit transfers
//   size_i            : unit size code (0 byte, 1 half, 2 word)
//   src_inc_i         : source pointer increment enable
//   dst_inc_i         : destination pointer increment enable
//   rd_req, wr_req    : bus read and write requests
//   addr_o, size_o    : bus address and unit size
//   bus_ack           : bus phase complete
//   rd_data_i         : read data, valid with bus_ack
//   wr_data_o         : buffered data for the write
//   busy              : status, high in any non-IDLE state
//   done              : status, one-cycle pulse on completion
//   err               : status, sticky error flag
//   remaining         : status, number of transfers left
// ----------------------------------------------------------------------------
module ahb_dma_chan_seq #(
   parameter int CNT_W     = 12,
   parameter int INC_SPLIT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [CNT_W-1:0] tot_sz_i,
   input  logic [2:0]       size_i,
   input  logic             src_inc_i,
   input  logic             dst_inc_i,
   output logic             rd_req,
   output logic             wr_req,
   output logic [31:0]      addr_o,
   output logic [2:0]       size_o,
   input  logic             bus_ack,
   input  logic [31:0]      rd_data_i,
   output logic [31:0]      wr_data_o,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] remaining
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_RD_INC = 3'd2,
      ST_WR     = 3'd3,
      ST_WR_INC = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t                state_r;
   logic [31:0]           src_ptr_r;
   logic [31:0]           dst_ptr_r;
   logic [31:0]           inc_in_s;
   logic [31:0]           step_s;
   logic [31:0]           inc_out_s;
   logic [INC_SPLIT:0]    low_sum_s;
   logic [31-INC_SPLIT:0] high_sum_s;
   logic                  cfg_bad_s;

   // An address is misaligned when its low bits are nonzero for the unit size.
   // Size codes above 2 are illegal, so they always report a violation.
   function automatic logic misaligned(input logic [31:0] addr, input logic [2:0] sz);
      case (sz)
         3'd0:    misaligned = 1'b0;
         3'd1:    misaligned = addr[0];
         3'd2:    misaligned = (addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   endfunction

   // Shared pointer incrementer. The low adder's carry ripples into the upper slice.
   always_comb begin
      if (state_r == ST_RD_INC) begin
         inc_in_s = src_ptr_r;
      end else begin
         inc_in_s = dst_ptr_r;
      end
      step_s     = 32'd1 << size_o;
      low_sum_s  = {1'b0, inc_in_s[INC_SPLIT-1:0]} + {1'b0, step_s[INC_SPLIT-1:0]};
      high_sum_s = inc_in_s[31:INC_SPLIT] + step_s[31:INC_SPLIT]
                   + {{(31-INC_SPLIT){1'b0}}, low_sum_s[INC_SPLIT]};
      inc_out_s  = {high_sum_s, low_sum_s[INC_SPLIT-1:0]};
   end

   // Configuration legality check, applied when a start arrives.
   always_comb begin
      cfg_bad_s = misaligned(src_addr_i, size_i) | misaligned(dst_addr_i, size_i);
   end

   // Sequencer FSM. All bus and status outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         src_ptr_r <= 32'd0;
         dst_ptr_r <= 32'd0;
         addr_o    <= 32'd0;
         wr_data_o <= 32'd0;
         remaining <= CNT_ZERO;
         size_o    <= 3'd0;
         rd_req    <= 1'b0;
         wr_req    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (cfg_bad_s) begin
                     err <= 1'b1;
                  end else if (tot_sz_i == CNT_ZERO) begin
                     err     <= 1'b0;
                     busy    <= 1'b1;
                     done    <= 1'b1;
                     state_r <= ST_DONE;
                  end else begin
                     err       <= 1'b0;
                     src_ptr_r <= src_addr_i;
                     dst_ptr_r <= dst_addr_i;
                     remaining <= tot_sz_i;
                     size_o    <= size_i;
                     addr_o    <= src_addr_i;
                     rd_req    <= 1'b1;
                     busy      <= 1'b1;
                     state_r   <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               // Abort takes priority over a simultaneous ack: the unit is dropped.
               if (abort) begin
                  rd_req  <= 1'b0;
                  wr_req  <= 1'b0;
                  busy    <= 1'b0;
                  err     <= 1'b1;
                  state_r <= ST_IDLE;
               end else if (bus_ack) begin
                  wr_data_o <= rd_data_i;
                  rd_req    <= 1'b0;
                  state_r   <= ST_RD_INC;
               end
            end
            ST_RD_INC: begin
               if (abort) begin
                  rd_req  <= 1'b0;
                  wr_req  <= 1'b0;
                  busy    <= 1'b0;
                  err     <= 1'b1;
                  state_r <= ST_IDLE;
               end else begin
                  if (src_inc_i) begin
                     src_ptr_r <= inc_out_s;
                  end
                  addr_o  <= dst_ptr_r;
                  wr_req  <= 1'b1;
                  state_r <= ST_WR;
               end
            end
            ST_WR: begin
               if (abort) begin
                  rd_req  <= 1'b0;
                  wr_req  <= 1'b0;
                  busy    <= 1'b0;
                  err     <= 1'b1;
                  state_r <= ST_IDLE;
               end else if (bus_ack) begin
                  wr_req  <= 1'b0;
                  state_r <= ST_WR_INC;
               end
            end
            ST_WR_INC: begin
               if (abort) begin
                  rd_req  <= 1'b0;
                  wr_req  <= 1'b0;
                  busy    <= 1'b0;
                  err     <= 1'b1;
                  state_r <= ST_IDLE;
               end else begin
                  if (dst_inc_i) begin
                     dst_ptr_r <= inc_out_s;
                  end
                  remaining <= remaining - CNT_ONE;
                  if (remaining == CNT_ONE) begin
                     done    <= 1'b1;
                     state_r <= ST_DONE;
                  end else begin
                     // src_ptr_r already holds the advanced source address.
                     addr_o  <= src_ptr_r;
                     rd_req  <= 1'b1;
                     state_r <= ST_RD;
                  end
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               rd_req  <= 1'b0;
               wr_req  <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_dma_chan_seq.sv
// ----------------------------------------------------------------------------
// Testbench for ahb_dma_chan_seq.
// Stimulus pushes the expected bus handshakes and done pulses into a queue.
// A monitor pops an entry and compares it each time the DUT completes a phase.
// ----------------------------------------------------------------------------
module tb_ahb_dma_chan_seq;

   typedef struct {
      logic [1:0]  kind;   // 0 read, 1 write, 2 done
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] src_addr_i = 32'd0;
   logic [31:0] dst_addr_i = 32'd0;
   logic [11:0] tot_sz_i = 12'd0;
   logic [2:0]  size_i = 3'd0;
   logic        src_inc_i = 1'b0;
   logic        dst_inc_i = 1'b0;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] addr_o;
   logic [2:0]  size_o;
   logic        bus_ack = 1'b0;
   logic [31:0] rd_data_i = 32'd0;
   logic [31:0] wr_data_o;
   logic        busy;
   logic        done;
   logic        err;
   logic [11:0] remaining;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int start_cyc = 0;
   int done_cyc = 0;
   int ack_delay = 0;
   int wait_cnt = 0;
   int rd_idx = 0;
   ev_t exp_q[$];

   ahb_dma_chan_seq #(.CNT_W(12), .INC_SPLIT(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .tot_sz_i(tot_sz_i),
      .size_i(size_i), .src_inc_i(src_inc_i), .dst_inc_i(dst_inc_i),
      .rd_req(rd_req), .wr_req(wr_req), .addr_o(addr_o), .size_o(size_o),
      .bus_ack(bus_ack), .rd_data_i(rd_data_i), .wr_data_o(wr_data_o),
      .busy(busy), .done(done), .err(err), .remaining(remaining)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event actual=kind%0d@%h required=none", k, a);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind", {30'd0, k}, {30'd0, e.kind});
         if (e.kind != 2'd2) chk("ev_addr", a, e.addr);
         if (e.kind == 2'd1) chk("ev_wdata", d, e.data);
      end
   endtask

   // Bus slave: acks each request after ack_delay wait cycles and supplies read data.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rd_req || wr_req) begin
            if (wait_cnt >= ack_delay) begin
               bus_ack = 1'b1;
               wait_cnt = 0;
               if (rd_req) begin
                  rd_data_i = 32'hA500_0000 + 32'(rd_idx);
                  rd_idx++;
               end
            end else begin
               bus_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            bus_ack = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // Monitor: checks exclusivity and hold stability, and scores completed phases.
   initial begin
      logic        prev_rd;
      logic        prev_wr;
      logic        prev_ack;
      logic [31:0] prev_addr;
      logic [31:0] prev_data;
      prev_rd = 1'b0; prev_wr = 1'b0; prev_ack = 1'b0;
      prev_addr = 32'd0; prev_data = 32'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_rd = 1'b0; prev_wr = 1'b0; prev_ack = 1'b0;
         end else begin
            chk("req_exclusive", {31'd0, rd_req & wr_req}, 32'd0);
            if (rd_req && prev_rd && !prev_ack) chk("rd_addr_hold", addr_o, prev_addr);
            if (wr_req && prev_wr && !prev_ack) begin
               chk("wr_addr_hold", addr_o, prev_addr);
               chk("wr_data_hold", wr_data_o, prev_data);
            end
            if (rd_req && bus_ack && !abort) pop_cmp(2'd0, addr_o, 32'd0);
            if (wr_req && bus_ack && !abort) pop_cmp(2'd1, addr_o, wr_data_o);
            if (done) begin
               done_cyc = cyc;
               pop_cmp(2'd2, 32'd0, 32'd0);
            end
            prev_rd = rd_req; prev_wr = wr_req; prev_ack = bus_ack;
            prev_addr = addr_o; prev_data = wr_data_o;
         end
      end
   end

   // Called at posedge+2; returns at posedge+2 right after the start edge.
   task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [11:0] t,
                           input logic [2:0] z, input logic si, input logic di);
      src_addr_i = s; dst_addr_i = d; tot_sz_i = t; size_i = z;
      src_inc_i = si; dst_inc_i = di;
      rd_idx = 0;
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL wait_idle_timeout actual=busy required=idle");
      end
   endtask

   initial begin
      int wcnt;
      // Reset values
      #2;
      chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
      chk("rst_wr_req", {31'd0, wr_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_addr", addr_o, 32'd0);
      chk("rst_wdata", wr_data_o, 32'd0);
      chk("rst_remaining", {20'd0, remaining}, 32'd0);
      chk("rst_size", {29'd0, size_o}, 32'd0);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;

      // Word copy, bus_ack always high
      ack_delay = 0;
      push(2'd0, 32'h2000_0000, 32'd0); push(2'd1, 32'h2000_1000, 32'hA500_0000);
      push(2'd0, 32'h2000_0004, 32'd0); push(2'd1, 32'h2000_1004, 32'hA500_0001);
      push(2'd0, 32'h2000_0008, 32'd0); push(2'd1, 32'h2000_1008, 32'hA500_0002);
      push(2'd0, 32'h2000_000C, 32'd0); push(2'd1, 32'h2000_100C, 32'hA500_0003);
      push(2'd2, 32'd0, 32'd0);
      do_start(32'h2000_0000, 32'h2000_1000, 12'd4, 3'd2, 1'b1, 1'b1);
      wait_idle(100);
      chk("copy_done_latency", 32'(done_cyc - start_cyc), 32'd17);
      chk("copy_remaining", {20'd0, remaining}, 32'd0);
      chk("copy_err", {31'd0, err}, 32'd0);
      chk("copy_size_o", {29'd0, size_o}, 32'd2);
      chk("copy_drained", 32'(exp_q.size()), 32'd0);

      // Carry across the incrementer split, halfword units
      push(2'd0, 32'h0000_FFFE, 32'd0); push(2'd1, 32'h0000_3000, 32'hA500_0000);
      push(2'd0, 32'h0001_0000, 32'd0); push(2'd1, 32'h0000_3002, 32'hA500_0001);
      push(2'd2, 32'd0, 32'd0);
      do_start(32'h0000_FFFE, 32'h0000_3000, 12'd2, 3'd1, 1'b1, 1'b1);
      wait_idle(100);
      chk("carry_drained", 32'(exp_q.size()), 32'd0);

      // Destination wraps modulo 2^32
      push(2'd0, 32'h0000_0100, 32'd0); push(2'd1, 32'hFFFF_FFFC, 32'hA500_0000);
      push(2'd0, 32'h0000_0104, 32'd0); push(2'd1, 32'h0000_0000, 32'hA500_0001);
      push(2'd2, 32'd0, 32'd0);
      do_start(32'h0000_0100, 32'hFFFF_FFFC, 12'd2, 3'd2, 1'b1, 1'b1);
      wait_idle(100);
      chk("wrap_drained", 32'(exp_q.size()), 32'd0);

      // Fixed destination with two wait states per phase
      ack_delay = 2;
      push(2'd0, 32'h4000_0000, 32'd0); push(2'd1, 32'h5000_0000, 32'hA500_0000);
      push(2'd0, 32'h4000_0004, 32'd0); push(2'd1, 32'h5000_0000, 32'hA500_0001);
      push(2'd0, 32'h4000_0008, 32'd0); push(2'd1, 32'h5000_0000, 32'hA500_0002);
      push(2'd2, 32'd0, 32'd0);
      do_start(32'h4000_0000, 32'h5000_0000, 12'd3, 3'd2, 1'b1, 1'b0);
      wait_idle(200);
      chk("fixed_remaining", {20'd0, remaining}, 32'd0);
      chk("fixed_drained", 32'(exp_q.size()), 32'd0);
      ack_delay = 0;

      // Abort in the same cycle as the second write ack
      push(2'd0, 32'h6000_0000, 32'd0); push(2'd1, 32'h7000_0000, 32'hA500_0000);
      push(2'd0, 32'h6000_0004, 32'd0);
      do_start(32'h6000_0000, 32'h7000_0000, 12'd4, 3'd2, 1'b1, 1'b1);
      wcnt = 0;
      for (int n = 0; n < 100 && wcnt < 2; n++) begin
         if (wr_req) wcnt++;
         if (wcnt < 2) begin
            @(posedge clk);
            #2;
         end
      end
      chk("abort_second_wr_seen", 32'(wcnt), 32'd2);
      chk("abort_ack_coincide", {31'd0, bus_ack}, 32'd1);
      abort = 1'b1;
      @(posedge clk); #2;
      abort = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_err", {31'd0, err}, 32'd1);
      chk("abort_remaining", {20'd0, remaining}, 32'd3);
      chk("abort_wr_req", {31'd0, wr_req}, 32'd0);
      repeat (3) @(posedge clk);
      #2;
      chk("abort_drained", 32'(exp_q.size()), 32'd0);
      // A fresh valid start clears err
      push(2'd0, 32'h6000_0100, 32'd0); push(2'd1, 32'h7000_0100, 32'hA500_0000);
      push(2'd2, 32'd0, 32'd0);
      do_start(32'h6000_0100, 32'h7000_0100, 12'd1, 3'd2, 1'b1, 1'b1);
      chk("restart_err_clear", {31'd0, err}, 32'd0);
      wait_idle(100);
      chk("restart_drained", 32'(exp_q.size()), 32'd0);

      // Illegal size code
      do_start(32'h0000_1000, 32'h0000_2000, 12'd2, 3'd3, 1'b1, 1'b1);
      chk("ill_size_err", {31'd0, err}, 32'd1);
      chk("ill_size_busy", {31'd0, busy}, 32'd0);
      chk("ill_size_rd_req", {31'd0, rd_req}, 32'd0);
      // Zero-length transfer: done next cycle, no bus activity
      push(2'd2, 32'd0, 32'd0);
      do_start(32'h0000_1000, 32'h0000_2000, 12'd0, 3'd2, 1'b1, 1'b1);
      chk("zero_err_clear", {31'd0, err}, 32'd0);
      wait_idle(10);
      chk("zero_done_latency", 32'(done_cyc - start_cyc), 32'd1);
      chk("zero_drained", 32'(exp_q.size()), 32'd0);
      // Misaligned word source
      do_start(32'h2000_0002, 32'h0000_2000, 12'd2, 3'd2, 1'b1, 1'b1);
      chk("misalign_err", {31'd0, err}, 32'd1);
      @(posedge clk); #2;
      chk("misalign_busy", {31'd0, busy}, 32'd0);
      chk("misalign_rd_req", {31'd0, rd_req}, 32'd0);

      // Asynchronous reset while a read waits for its ack
      ack_delay = 5;
      do_start(32'h8000_0000, 32'h9000_0000, 12'd2, 3'd2, 1'b1, 1'b1);
      @(posedge clk); #3;
      chk("arst_pre_rd_req", {31'd0, rd_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_rd_req", {31'd0, rd_req}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_addr", addr_o, 32'd0);
      chk("arst_remaining", {20'd0, remaining}, 32'd0);
      chk("arst_size", {29'd0, size_o}, 32'd0);
      chk("arst_err", {31'd0, err}, 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      ack_delay = 0;
      @(posedge clk); #2;
      chk("final_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
